// File: rtl/rv_fetch_unit.sv
// Purpose: instruction fetch stage; walks the PC, reads imem one word at a time, queues instructions for decode.
// Latency: imem ack in cycle N -> instruction at queue head (inst_valid_o) in cycle N+1.
// Backpressure: a read is only issued when a queue slot is guaranteed; a full queue simply idles imem.
module rv_fetch_unit #(
    parameter int MEM_ADDR_WIDTH = 64,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int QUEUE_DEPTH    = 4
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic [MEM_ADDR_WIDTH-1:0] boot_addr_i,
    output logic                      imem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [MEM_DATA_WIDTH-1:0] imem_data_i,
    input  logic                      imem_ack_i,
    input  logic                      redirect_i,
    input  logic [MEM_ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                      inst_valid_o,
    output logic [31:0]               inst_o,
    output logic [MEM_ADDR_WIDTH-1:0] inst_pc_o,
    input  logic                      inst_ready_i
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]          DEPTH_C    = CNT_W'(QUEUE_DEPTH);
    localparam logic [MEM_ADDR_WIDTH-1:0] WORD_MASK  = ~(MEM_ADDR_WIDTH'(MEM_DATA_WIDTH / 8 - 1));
    localparam logic [MEM_ADDR_WIDTH-1:0] INST_MASK  = ~(MEM_ADDR_WIDTH'(3));
    localparam logic [MEM_ADDR_WIDTH-1:0] INST_BYTES = MEM_ADDR_WIDTH'(4);

    localparam logic [1:0] ST_BOOT    = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_REQ     = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    // Unsupported configurations stop elaboration instead of producing a silently broken fetch unit.
    if (!(MEM_DATA_WIDTH == 32 || MEM_DATA_WIDTH == 64)) begin : g_bad_data_width
        $fatal(1, "rv_fetch_unit: MEM_DATA_WIDTH must be 32 or 64");
    end
    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_queue_depth
        $fatal(1, "rv_fetch_unit: QUEUE_DEPTH must be a power of 2 and >= 2");
    end

    logic [1:0]                state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [31:0]               inst_mem_q [QUEUE_DEPTH];
    logic [31:0]               inst_mem_d [QUEUE_DEPTH];
    logic [MEM_ADDR_WIDTH-1:0] pc_mem_q [QUEUE_DEPTH];
    logic [MEM_ADDR_WIDTH-1:0] pc_mem_d [QUEUE_DEPTH];

    logic                      redirect_vld;
    logic                      push;
    logic                      pop;
    logic [31:0]               fetch_inst;
    logic [MEM_ADDR_WIDTH-1:0] redirect_pc;

    // A 64-bit word holds two instructions; pc[2] picks the half that belongs to the fetched PC.
    if (MEM_DATA_WIDTH == 64) begin : g_lane64
        assign fetch_inst = pc_q[2] ? imem_data_i[63:32] : imem_data_i[31:0];
    end else begin : g_lane32
        assign fetch_inst = imem_data_i[31:0];
    end

    // Redirects are ignored while booting; a pop in the redirect cycle still counts as accepted.
    assign redirect_vld = redirect_i && (state_q != ST_BOOT);
    assign redirect_pc  = redirect_pc_i & INST_MASK;
    assign pop          = (count_q != '0) && inst_ready_i;
    assign push         = (state_q == ST_REQ) && imem_ack_i && !redirect_vld;

    // Instruction queue: wrap-around pointers plus occupancy count; a redirect empties it.
    always_comb begin
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_vld) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                inst_mem_d[wr_ptr_q] = fetch_inst;
                pc_mem_d[wr_ptr_q]   = pc_q;
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
        end
    end

    // Fetch FSM: a new read starts only when the post-push/pop occupancy still leaves a slot for it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        case (state_q)
            ST_BOOT: begin
                pc_d    = boot_addr_i;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (redirect_vld) begin
                    pc_d = redirect_pc;
                end else if (count_d < DEPTH_C) begin
                    addr_d  = pc_q & WORD_MASK;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_vld) begin
                    // The outstanding handshake must still complete; its data is dropped.
                    pc_d    = redirect_pc;
                    state_d = imem_ack_i ? ST_IDLE : ST_DISCARD;
                end else if (imem_ack_i) begin
                    pc_d = pc_q + INST_BYTES;
                    if (count_d < DEPTH_C) begin
                        addr_d  = (pc_q + INST_BYTES) & WORD_MASK;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (redirect_vld) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State registers; reset forgets any in-flight read.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q  <= ST_BOOT;
            pc_q     <= '0;
            addr_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inst_mem_q <= inst_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end

    assign imem_req_o   = (state_q == ST_REQ) || (state_q == ST_DISCARD);
    assign imem_addr_o  = addr_q;
    assign inst_valid_o = (count_q != '0);
    assign inst_o       = inst_valid_o ? inst_mem_q[rd_ptr_q] : '0;
    assign inst_pc_o    = inst_valid_o ? pc_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit: a behavioural imem plus a program-order model of the expected instruction stream.
// The model only knows "next PC is previous + 4 unless redirected" and a fixed PC->instruction mapping.
// Directed scenarios first, then a long randomized run with random stalls, ack delays and redirects.
module tb_rv_fetch_unit;

    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b1;
    logic [63:0] boot_addr_i = '0;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic [63:0] imem_data_i = '0;
    logic        imem_ack_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [63:0] inst_pc_o;
    logic        inst_ready_i = 1'b0;

    rv_fetch_unit #(
        .MEM_ADDR_WIDTH(64),
        .MEM_DATA_WIDTH(64),
        .QUEUE_DEPTH   (4)
    ) dut (
        .clk_i        (clk_i),
        .arst_ni      (arst_ni),
        .boot_addr_i  (boot_addr_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_i  (imem_data_i),
        .imem_ack_i   (imem_ack_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_ready_i (inst_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ready_pct = 100;
    int          ack_dly = -1;
    logic        pend = 1'b0;
    int          wait_cnt = 0;
    logic [63:0] pend_addr = '0;
    logic [63:0] exp_pc = '0;
    logic [63:0] req_log[$];
    logic [63:0] pop_log[$];
    int          n_ack = 0;
    int          n_pop = 0;
    int          cyc = 0;
    int          first_ack_cyc = -1;
    int          first_vld_cyc = -1;
    logic        redir_req = 1'b0;
    logic [63:0] redir_tgt = '0;

    // Instruction stored at a given byte address of the modelled program.
    function automatic logic [31:0] inst_fn(input logic [63:0] pc);
        return (pc[31:0] * 32'h9E37_79B1) ^ pc[63:32] ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] qat(input logic [63:0] q[$], input int i);
        return (i < q.size()) ? q[i] : '1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: imem responds, decode decides readiness, the stream model checks any accepted head.
    task automatic step();
        @(negedge clk_i);
        cyc++;
        imem_ack_i  = 1'b0;
        imem_data_i = {$urandom, $urandom};
        if (imem_req_o) begin
            if (!pend) begin
                pend      = 1'b1;
                pend_addr = imem_addr_o;
                wait_cnt  = (ack_dly >= 0) ? ack_dly : $urandom_range(0, 3);
                req_log.push_back(imem_addr_o);
                chk("addr_align", {61'd0, imem_addr_o[2:0]}, 64'd0);
            end else begin
                chk("addr_stable", imem_addr_o, pend_addr);
            end
            if (wait_cnt == 0) begin
                imem_ack_i  = 1'b1;
                imem_data_i = {inst_fn(pend_addr + 64'd4), inst_fn(pend_addr)};
                pend        = 1'b0;
                n_ack++;
                if (first_ack_cyc < 0) first_ack_cyc = cyc;
            end else begin
                wait_cnt--;
            end
        end
        inst_ready_i = ($urandom_range(0, 99) < ready_pct);
        if (inst_valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (inst_valid_o && inst_ready_i) begin
            chk("head_pc", inst_pc_o, exp_pc);
            chk("head_inst", {32'd0, inst_o}, {32'd0, inst_fn(exp_pc)});
            pop_log.push_back(inst_pc_o);
            n_pop++;
            exp_pc = exp_pc + 64'd4;
        end
        redirect_i    = redir_req;
        redirect_pc_i = redir_tgt;
        if (redir_req) exp_pc = redir_tgt & ~64'd3;
        redir_req = 1'b0;
    endtask

    task automatic do_reset(input logic [63:0] boot);
        @(negedge clk_i);
        arst_ni      = 1'b0;
        imem_ack_i   = 1'b0;
        redirect_i   = 1'b0;
        inst_ready_i = 1'b0;
        boot_addr_i  = boot;
        redir_req    = 1'b0;
        #1;
        chk("rst_req", {63'd0, imem_req_o}, 64'd0);
        chk("rst_addr", imem_addr_o, 64'd0);
        chk("rst_valid", {63'd0, inst_valid_o}, 64'd0);
        chk("rst_inst", {32'd0, inst_o}, 64'd0);
        chk("rst_pc", inst_pc_o, 64'd0);
        repeat (2) @(negedge clk_i);
        arst_ni = 1'b1;
        pend    = 1'b0;
        exp_pc  = boot;
        req_log.delete();
        pop_log.delete();
        n_ack         = 0;
        n_pop         = 0;
        cyc           = 0;
        first_ack_cyc = -1;
        first_vld_cyc = -1;
    endtask

    task automatic wait_pending();
        for (int i = 0; i < 20 && !pend; i++) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Sequential fetch across word halves, 1-cycle ack, decode always ready.
        ready_pct = 100;
        ack_dly   = 1;
        do_reset(64'h8000_0000);
        repeat (20) step();
        chk("t1_addr0", qat(req_log, 0), 64'h8000_0000);
        chk("t1_addr1", qat(req_log, 1), 64'h8000_0000);
        chk("t1_addr2", qat(req_log, 2), 64'h8000_0008);
        chk("t1_pc0", qat(pop_log, 0), 64'h8000_0000);
        chk("t1_pc1", qat(pop_log, 1), 64'h8000_0004);
        chk("t1_pc2", qat(pop_log, 2), 64'h8000_0008);
        chk("t1_latency", 64'(first_vld_cyc - first_ack_cyc), 64'd1);

        // Decode stalled: exactly a queue's worth of reads, then fetch idles until space frees.
        ready_pct = 0;
        ack_dly   = 0;
        do_reset(64'h4000);
        repeat (15) step();
        chk("t2_pushes", 64'(n_ack), 64'd4);
        chk("t2_req_idle", {63'd0, imem_req_o}, 64'd0);
        chk("t2_valid_held", {63'd0, inst_valid_o}, 64'd1);
        chk("t2_head_held", inst_pc_o, 64'h4000);
        ready_pct = 100;
        step();
        @(posedge clk_i);
        #1;
        chk("t2_resume", {63'd0, imem_req_o}, 64'd1);
        repeat (20) step();
        chk("t2_drained", 64'(n_pop >= 8), 64'd1);

        // Redirect while a slow read is outstanding.
        ack_dly = 3;
        do_reset(64'h1000);
        wait_pending();
        chk("t3_pending", {63'd0, pend}, 64'd1);
        req_log.delete();
        pop_log.delete();
        redir_req = 1'b1;
        redir_tgt = 64'h100;
        repeat (30) step();
        chk("t3_addr", qat(req_log, 0), 64'h100);
        chk("t3_pc", qat(pop_log, 0), 64'h100);

        // Redirect coinciding with the ack.
        ack_dly = 2;
        do_reset(64'h2000);
        for (int i = 0; i < 20 && !(pend && wait_cnt == 0); i++) step();
        chk("t4_ack_next", {63'd0, pend && wait_cnt == 0}, 64'd1);
        req_log.delete();
        pop_log.delete();
        redir_req = 1'b1;
        redir_tgt = 64'h200;
        step();
        chk("t4_ack_seen", {63'd0, imem_ack_i}, 64'd1);
        repeat (30) step();
        chk("t4_addr", qat(req_log, 0), 64'h200);
        chk("t4_pc", qat(pop_log, 0), 64'h200);

        // Two redirects back to back while discarding.
        ack_dly = 3;
        do_reset(64'h3000);
        wait_pending();
        req_log.delete();
        pop_log.delete();
        redir_req = 1'b1;
        redir_tgt = 64'h300;
        step();
        redir_req = 1'b1;
        redir_tgt = 64'h400;
        repeat (30) step();
        chk("t5_addr", qat(req_log, 0), 64'h400);
        chk("t5_pc", qat(pop_log, 0), 64'h400);

        // Reset in the middle of an outstanding read, then boot from a new address.
        ack_dly = 3;
        do_reset(64'h6000);
        wait_pending();
        do_reset(64'h7000);
        repeat (30) step();
        chk("t6_addr", qat(req_log, 0), 64'h7000);
        chk("t6_pc", qat(pop_log, 0), 64'h7000);

        // Randomized run starting just below the top of the address space so the PC wraps.
        ack_dly   = -1;
        ready_pct = 70;
        do_reset(64'hFFFF_FFFF_FFFF_FFE8);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                redir_req = 1'b1;
                redir_tgt = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                                          : {32'd0, $urandom};
            end
            step();
        end
        chk("rand_progress", 64'(n_pop > 500), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
